// File: rtl/data_mem_ctrl.sv
// ============================================================================
//  Module   : data_mem_ctrl
//  Purpose  : MEM-stage data memory controller. Byte/halfword/word load and
//             store with fixed LATENCY wait cycles and a Ready pulse.
//  Option   : DMEM_ZERO_LATENCY_EN - aligned accesses commit at acceptance
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Req,
   input  logic        WE,
   input  logic [1:0]  Size,
   input  logic        SignExt,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Busy,
   output logic        AlignErr
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW+1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [1:0]    size_q, size_d;
   logic          sext_q, sext_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          alignerr_q, alignerr_d;

   logic [31:0]   mem_q [DEPTH_WORDS] = '{default: 32'h0};

   logic          accept;
   logic          commit;
   logic [AW+1:0] c_addr;
   logic          c_we;
   logic [1:0]    c_size;
   logic          c_sext;
   logic [31:0]   c_wdata;
   logic [AW-1:0] mem_idx;
   logic [31:0]   mem_rword;
   logic          mem_wr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;

   logic          unused_addr_hi;
   assign unused_addr_hi = ^Addr[31:AW+2];

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return (off != 2'b00);
      endcase
   endfunction

   // Right-justify the addressed byte/half and extend; words pass through.
   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic sext);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*off +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = {{24{sext & b[7]}}, b};
         2'b01:   r = {{16{sext & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      size_d     = size_q;
      sext_d     = sext_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      busy_d     = busy_q;
      alignerr_d = alignerr_q;
      commit     = 1'b0;
      c_addr     = addr_q;
      c_we       = we_q;
      c_size     = size_q;
      c_sext     = sext_q;
      c_wdata    = wdata_q;
      accept     = Req && ((state_q == S_IDLE) || (state_q == S_DONE));

      case (state_q)
         S_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             commit = 1'b1;
         end
         S_DONE: begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            alignerr_d = 1'b0;
            rdata_d    = '0;
         end
         default: ;
      endcase

      // The edge that closes the Ready cycle doubles as the next accept edge.
      if (accept) begin
         addr_d     = Addr[AW+1:0];
         we_d       = WE;
         size_d     = Size;
         sext_d     = SignExt;
         wdata_d    = WriteData;
         busy_d     = 1'b1;
         cnt_d      = CW'(LATENCY - 1);
         alignerr_d = 1'b0;
         rdata_d    = '0;
         if (misaligned(Size, Addr[1:0])) begin
            state_d    = S_DONE;
            ready_d    = 1'b1;
            alignerr_d = 1'b1;
         end else begin
`ifdef DMEM_ZERO_LATENCY_EN
            commit  = 1'b1;
            c_addr  = Addr[AW+1:0];
            c_we    = WE;
            c_size  = Size;
            c_sext  = SignExt;
            c_wdata = WriteData;
`else
            state_d = S_WAIT;
`endif
         end
      end

      if (commit) begin
         state_d = S_DONE;
         ready_d = 1'b1;
      end
   end

   always_comb begin
      mem_idx   = c_addr[AW+1:2];
      mem_rword = mem_q[mem_idx];
      mem_wr    = commit && c_we && !Reset;
      mem_be    = 4'b1111;
      mem_wdata = c_wdata;
      case (c_size)
         2'b00: begin
            mem_be    = 4'b0001 << c_addr[1:0];
            mem_wdata = {4{c_wdata[7:0]}};
         end
         2'b01: begin
            mem_be    = c_addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{c_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   logic [31:0] load_data;
   assign load_data = extract(mem_rword, c_addr[1:0], c_size, c_sext);

   // Array contents survive reset; only the control path is cleared.
   always_ff @(posedge CLK) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         sext_q     <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         alignerr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         wdata_q    <= wdata_d;
         rdata_q    <= (commit && !c_we) ? load_data : rdata_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         alignerr_q <= alignerr_d;
      end
   end

   assign ReadData = rdata_q;
   assign Ready    = ready_q;
   assign Busy     = busy_q;
   assign AlignErr = alignerr_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Purpose  : Self-checking bench for data_mem_ctrl against a byte-array model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;
   localparam int MEMB  = DEPTH * 4;
`ifdef DMEM_ZERO_LATENCY_EN
   localparam bit ZL = 1'b1;
`else
   localparam bit ZL = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [1:0]  size  = 2'b00;
   logic        sext  = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        aerr;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  mem_m [MEMB];
   logic [31:0] rd;
   logic        seen;

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .CLK       (clk),
      .Reset     (rst),
      .Req       (req),
      .WE        (we),
      .Size      (size),
      .SignExt   (sext),
      .Addr      (addr),
      .WriteData (wdata),
      .ReadData  (rdata),
      .Ready     (ready),
      .Busy      (busy),
      .AlignErr  (aerr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit model_aligned(input logic [31:0] a, input logic [1:0] sz);
      return (a % nbytes(sz)) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input logic sx);
      int          base;
      int          nb;
      logic [31:0] v;
      base = int'(a % MEMB);
      nb   = nbytes(sz);
      v    = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_m[(base + i) % MEMB]) << (8 * i));
      if (nb < 4 && sx && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      int base;
      base = int'(a % MEMB);
      for (int i = 0; i < nbytes(sz); i++) mem_m[(base + i) % MEMB] = 8'(wd >> (8 * i));
   endtask

   task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] r);
      int          n;
      logic        mis;
      logic [31:0] exp_rd;
      int          exp_n;
      mis    = !model_aligned(a, sz);
      exp_rd = (mis || w) ? 32'h0 : model_load(a, sz, sx);
      exp_n  = (mis || ZL) ? 0 : LAT;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
      @(posedge clk); #1;
      req = 1'b0;
      n = 0;
      while (!ready && n < 64) begin
         chk("busy_wait", 32'(busy), 32'h1);
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, exp_n);
      chk("busy_rdy", 32'(busy), 32'h1);
      chk("align_err", 32'(aerr), 32'(mis));
      chk("read_data", rdata, exp_rd);
      r = rdata;
      if (!mis && w) model_store(a, sz, wd);
      @(posedge clk); #1;
      chk("ready_pulse", 32'(ready), 32'h0);
      chk("busy_idle", 32'(busy), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r1, r2, drop;
      logic [31:0] a;
      logic [1:0]  sz;
      for (int i = 0; i < MEMB; i++) mem_m[i] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_aerr", 32'(aerr), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
      chk("word_load", rd, 32'hDEADBEEF);
      access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, rd);
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
      chk("byte_merge", rd, 32'hDEADA5EF);
      access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd);
      chk("byte_sext", rd, 32'hFFFFFFA5);
      access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd);
      chk("byte_zext", rd, 32'h000000A5);
      access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd);
      chk("half_sext", rd, 32'hFFFFDEAD);
      access(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, rd);
      chk("half_mis_rd", rd, 32'h0);
      access(1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, rd);
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
      chk("mis_nowrite", rd, 32'hDEADA5EF);

      // Req held high: one access per Ready, next accepted on the edge after Ready.
      r1   = ZL ? 0 : LAT;
      r2   = ZL ? 1 : 2 * LAT + 1;
      drop = ZL ? 1 : LAT + 1;
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10;
      @(posedge clk); #1;
      for (int n = 0; n <= 2 * LAT + 3; n++) begin
         chk("held_ready", 32'(ready), 32'((n == r1) || (n == r2)));
         if (n == r1 || n == r2) chk("held_data", rdata, model_load(32'h10, 2'b10, 1'b0));
         if (n == drop) req = 1'b0;
         @(posedge clk); #1;
      end

      // Reset during the wait of a store aborts it.
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk); #1;
      req = 1'b0;
      rst = 1'b1;
      if (ZL) model_store(32'h20, 2'b10, 32'h12345678);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ready", 32'(ready), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_aerr", 32'(aerr), 32'h0);
      chk("abort_rdata", rdata, 32'h0);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | ready;
      end
      chk("abort_noready", 32'(seen), 32'h0);
      access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);

      // Addresses wrap modulo the array size.
      access(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, rd);
      access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, rd);
      chk("wrap", rd, 32'hCAFEF00D);

      for (int i = 0; i < 150; i++) begin
         a  = 32'($urandom_range(0, 2 * MEMB - 1));
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz[1])       a[1:0] = 2'b00;
         end
         access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
